imuldiv_muldiv_issue_unit: RTL and testbench



---
 rtl/imuldiv_muldiv_issue_unit_pkg.sv | 31 +++
 rtl/imuldiv_muldiv_issue_unit_result_sel.sv | 18 +
 rtl/imuldiv_muldiv_issue_unit.sv | 153 +++++++++++++++
 tb/tb_imuldiv_muldiv_issue_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_muldiv_issue_unit_pkg.sv
// rtl/imuldiv_muldiv_issue_unit_pkg.sv - shared mul/div request-message header
//
// Purpose: function-code constants for the mul/div request message, the
//          issue-unit FSM state encoding, and small fn decode helpers.
// Ports:   none (package).
package imuldiv_muldiv_issue_unit_pkg;

  localparam logic [2:0] MD_FN_MUL  = 3'd0;
  localparam logic [2:0] MD_FN_DIV  = 3'd1;
  localparam logic [2:0] MD_FN_DIVU = 3'd2;
  localparam logic [2:0] MD_FN_REM  = 3'd3;
  localparam logic [2:0] MD_FN_REMU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } issue_state_t;

  // Codes 5..7 have no operation behind them.
  function automatic logic fn_is_legal(input logic [2:0] fn);
    return (fn <= MD_FN_REMU);
  endfunction

  // Remainder ops return the upper word of the 64-bit response.
  function automatic logic fn_is_rem(input logic [2:0] fn);
    return (fn == MD_FN_REM) || (fn == MD_FN_REMU);
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_issue_unit_result_sel.sv
// rtl/imuldiv_muldiv_issue_unit_result_sel.sv - 32-bit result word select
//
// Purpose: pick the architectural 32-bit word out of the 64-bit mul/div
//          response according to the function code.
// Ports:   fn     in  3   captured function code
//          result in  64  response; [31:0] quotient/product, [63:32] remainder
//          word   out 32  selected word
module imuldiv_issue_result_sel
  import imuldiv_muldiv_issue_unit_pkg::*;
(
  input  logic [2:0]  fn,
  input  logic [63:0] result,
  output logic [31:0] word
);

  assign word = fn_is_rem(fn) ? result[63:32] : result[31:0];

endmodule

// File: rtl/imuldiv_muldiv_issue_unit.sv
// rtl/imuldiv_muldiv_issue_unit.sv - requester-side issue controller for the mul/div unit
//
// Purpose: accept one tagged command, issue it over the val/rdy request
//          channel, collect the 64-bit response and write back the selected
//          32-bit word. One operation in flight at a time.
// Ports:   clk, reset_n                 clock, async active-low reset
//          cmd_val/rdy/fn/a/b/tag       command from execute
//          muldivreq_val/rdy/msg_*      request to the mul/div unit (registered)
//          muldivresp_val/rdy/msg_result response from the mul/div unit
//          wb_val/rdy/data/tag/err      writeback (registered)
//          perf_ops, perf_busy          only with IMULDIV_ISSUE_PERF_EN defined
module imuldiv_muldiv_issue_unit
  import imuldiv_muldiv_issue_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [2:0]  cmd_fn,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [4:0]  cmd_tag,
  output logic        muldivreq_val,
  input  logic        muldivreq_rdy,
  output logic [2:0]  muldivreq_msg_fn,
  output logic [31:0] muldivreq_msg_a,
  output logic [31:0] muldivreq_msg_b,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy,
  input  logic [63:0] muldivresp_msg_result,
  output logic        wb_val,
  input  logic        wb_rdy,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_tag,
  output logic        wb_err
`ifdef IMULDIV_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_busy
`endif
);

  issue_state_t state, state_nxt;

  logic [2:0]  fn_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  tag_q;
  logic [31:0] wb_data_q;
  logic        wb_err_q;
  logic [31:0] sel_word;

  logic cmd_fire;
  logic resp_fire;
  logic wb_fire;

  assign cmd_fire  = cmd_val && cmd_rdy;
  assign resp_fire = muldivresp_val && muldivresp_rdy;
  assign wb_fire   = wb_val && wb_rdy;

  imuldiv_issue_result_sel u_result_sel (
    .fn     (fn_q),
    .result (muldivresp_msg_result),
    .word   (sel_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cmd_rdy        = 1'b0;
    muldivreq_val  = 1'b0;
    muldivresp_rdy = 1'b0;
    wb_val         = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          // Illegal codes skip the unit entirely and report through wb_err.
          state_nxt = fn_is_legal(cmd_fn) ? ST_REQ : ST_WB;
        end
      end
      ST_REQ: begin
        muldivreq_val = 1'b1;
        if (muldivreq_rdy) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        muldivresp_rdy = 1'b1;
        if (muldivresp_val) state_nxt = ST_WB;
      end
      ST_WB: begin
        wb_val = 1'b1;
        if (wb_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fn_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      tag_q     <= 5'd0;
      wb_data_q <= 32'd0;
      wb_err_q  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        fn_q  <= cmd_fn;
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        tag_q <= cmd_tag;
        if (!fn_is_legal(cmd_fn)) begin
          wb_data_q <= 32'd0;
          wb_err_q  <= 1'b1;
        end
      end
      if (resp_fire) begin
        wb_data_q <= sel_word;
        wb_err_q  <= 1'b0;
      end
    end
  end

  assign muldivreq_msg_fn = fn_q;
  assign muldivreq_msg_a  = a_q;
  assign muldivreq_msg_b  = b_q;
  assign wb_data          = wb_data_q;
  assign wb_tag           = tag_q;
  assign wb_err           = wb_err_q;

`ifdef IMULDIV_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ops  <= 32'd0;
      perf_busy <= 32'd0;
    end else begin
      if (wb_fire)          perf_ops  <= perf_ops + 32'd1;
      if (state != ST_IDLE) perf_busy <= perf_busy + 32'd1;
    end
  end
`else
  logic unused_wb_fire;
  assign unused_wb_fire = wb_fire;
`endif

endmodule

// File: tb/tb_imuldiv_muldiv_issue_unit.sv
// tb/tb_imuldiv_muldiv_issue_unit.sv - scoreboard bench for the mul/div issue unit
module tb_imuldiv_muldiv_issue_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [2:0]  cmd_fn;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [4:0]  cmd_tag;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        wb_val;
  logic        wb_rdy;
  logic [31:0] wb_data;
  logic [4:0]  wb_tag;
  logic        wb_err;
`ifdef IMULDIV_ISSUE_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_busy;
`endif

  always #5 clk = ~clk;

  imuldiv_muldiv_issue_unit dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .cmd_val               (cmd_val),
    .cmd_rdy               (cmd_rdy),
    .cmd_fn                (cmd_fn),
    .cmd_a                 (cmd_a),
    .cmd_b                 (cmd_b),
    .cmd_tag               (cmd_tag),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy),
    .wb_data               (wb_data),
    .wb_tag                (wb_tag),
    .wb_err                (wb_err)
`ifdef IMULDIV_ISSUE_PERF_EN
    ,
    .perf_ops              (perf_ops),
    .perf_busy             (perf_busy)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
  } wb_exp_t;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
  } req_exp_t;

  wb_exp_t     sb_q[$];
  req_exp_t    req_q[$];
  logic [63:0] resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int wb_cnt   = 0;
  int resp_delay = 4;
  bit resp_en  = 1'b1;
  bit model_busy = 1'b0;
  int model_busy_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder: checks each request message, then answers after resp_delay cycles.
  initial begin
    muldivresp_val        = 1'b0;
    muldivresp_msg_result = 64'd0;
    forever begin
      @(negedge clk);
      if (reset_n && muldivreq_val && muldivreq_rdy) begin
        req_exp_t r;
        bit got;
        req_cnt++;
        if (req_q.size() == 0) begin
          chk("req_unexpected", 1, 0);
        end else begin
          r = req_q.pop_front();
          chk("req_fn", muldivreq_msg_fn, r.fn);
          chk("req_a", muldivreq_msg_a, r.a);
          chk("req_b", muldivreq_msg_b, r.b);
        end
        if (resp_en) begin
          @(posedge clk);
          repeat (resp_delay) @(posedge clk);
          #1;
          muldivresp_val = 1'b1;
          muldivresp_msg_result = (resp_q.size() != 0) ? resp_q.pop_front() : 64'd0;
          got = 1'b0;
          for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (muldivresp_rdy) begin
              got = 1'b1;
              break;
            end
          end
          if (!got) chk("resp_rdy_timeout", 0, 1);
          @(posedge clk);
          #1 muldivresp_val = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every writeback handshake against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (model_busy) model_busy_cnt++;
      if (wb_val && wb_rdy) begin
        wb_exp_t e;
        wb_cnt++;
        model_busy = 1'b0;
        if (sb_q.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_tag", wb_tag, e.tag);
          chk("wb_err", wb_err, e.err);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [63:0] resp,
                       input logic [31:0] exp_data, input logic exp_err, input bit expect_wb);
    bit ok;
    wb_exp_t e;
    req_exp_t r;
    if (expect_wb) begin
      e.data = exp_data; e.tag = tag; e.err = exp_err;
      sb_q.push_back(e);
    end
    if (fn <= 3'd4) begin
      r.fn = fn; r.a = a; r.b = b;
      req_q.push_back(r);
      if (resp_en) resp_q.push_back(resp);
    end
    @(posedge clk);
    #1;
    cmd_val = 1'b1; cmd_fn = fn; cmd_a = a; cmd_b = b; cmd_tag = tag;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
    model_busy = 1'b1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int r0;
    int w0;
    bit ok;
    reset_n = 1'b0;
    cmd_val = 1'b0; cmd_fn = 3'd0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_tag = 5'd0;
    muldivreq_rdy = 1'b1;
    wb_rdy = 1'b1;

    #12;
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_req_val", muldivreq_val, 0);
    chk("rst_resp_rdy", muldivresp_rdy, 0);
    chk("rst_wb_val", wb_val, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_tag", wb_tag, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_msg", {muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // MUL 7*6, responder replies after 4 cycles.
    r0 = req_cnt;
    issue(3'd0, 32'd7, 32'd6, 5'd3, 64'h0000_0000_0000_002A, 32'h2A, 1'b0, 1'b1);
    @(negedge clk);
    chk("mul_req_val_cycle1", muldivreq_val, 1);
    drain();
    chk("mul_one_request", req_cnt - r0, 1);

    // Signed divide/remainder of -7 by 2: quotient -3, remainder -1.
    issue(3'd1, 32'hFFFF_FFF9, 32'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b1);
    drain();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
    drain();
    // Unsigned 100/7: quotient 14, remainder 2.
    resp_delay = 0;
    issue(3'd2, 32'd100, 32'd7, 5'd6, 64'h0000_0002_0000_000E, 32'd14, 1'b0, 1'b1);
    drain();
    issue(3'd4, 32'd100, 32'd7, 5'd7, 64'h0000_0002_0000_000E, 32'd2, 1'b0, 1'b1);
    drain();
    resp_delay = 2;

    // Backpressure on both channels.
    r0 = req_cnt;
    w0 = wb_cnt;
    muldivreq_rdy = 1'b0;
    wb_rdy = 1'b0;
    issue(3'd0, 32'h10, 32'h20, 5'd9, 64'h200, 32'h200, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_val", muldivreq_val, 1);
      chk("bp_msg", {muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b}, {3'd0, 32'h10, 32'h20});
      chk("bp_cmd_rdy", cmd_rdy, 0);
    end
    @(posedge clk);
    #1 muldivreq_rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wb_val) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("bp_wb_val_timeout", 0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_wb_val", wb_val, 1);
      chk("bp_wb_data", wb_data, 32'h200);
      chk("bp_wb_tag", wb_tag, 9);
      chk("bp_wb_cmd_rdy", cmd_rdy, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 wb_rdy = 1'b1;
    drain();
    chk("bp_one_request", req_cnt - r0, 1);
    chk("bp_one_wb", wb_cnt - w0, 1);

    // Illegal function codes.
    r0 = req_cnt;
    issue(3'd6, 32'd1, 32'd2, 5'd10, 64'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ill_wb_val_cycle1", wb_val, 1);
    chk("ill_req_val", muldivreq_val, 0);
    drain();
    issue(3'd7, 32'd5, 32'd5, 5'd11, 64'd0, 32'd0, 1'b1, 1'b1);
    drain();
    chk("ill_no_request", req_cnt - r0, 0);

    // Reset while waiting for the response.
    resp_en = 1'b0;
    issue(3'd0, 32'd11, 32'd13, 5'd12, 64'd0, 32'd0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (muldivresp_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_state_timeout", 0, 1);
    reset_n = 1'b0;
    #1;
    model_busy = 1'b0;
    model_busy_cnt = 0;
    chk("mrst_cmd_rdy", cmd_rdy, 1);
    chk("mrst_req_val", muldivreq_val, 0);
    chk("mrst_resp_rdy", muldivresp_rdy, 0);
    chk("mrst_wb", {wb_val, wb_data, wb_tag, wb_err}, 0);
    chk("mrst_msg", {muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b}, 0);
`ifdef IMULDIV_ISSUE_PERF_EN
    chk("mrst_perf", {perf_ops, perf_busy}, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    resp_en = 1'b1;

    issue(3'd0, 32'd3, 32'd5, 5'd13, 64'd15, 32'd15, 1'b0, 1'b1);
    issue(3'd0, 32'd2, 32'd2, 5'd14, 64'd4, 32'd4, 1'b0, 1'b1);
    drain();
    @(negedge clk);
`ifdef IMULDIV_ISSUE_PERF_EN
    chk("perf_ops", perf_ops, 2);
    chk("perf_busy", perf_busy, model_busy_cnt);
`endif
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
